// File: rtl/bcd_time_loader.sv
// Keypad-loaded MM:SS BCD countdown timer. Digits shift in from the right while idle
// or paused, then count down once per 1 Hz tick under start/stop control.
module bcd_time_loader #(
  parameter logic [3:0] SEC_TENS_MAX = 4'd5,
  parameter logic [3:0] DIGIT_MAX    = 4'd9
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       load,
  input  logic [3:0] digit,
  input  logic       pgt_1hz,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       zero
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;

  logic load_q, tick_q, start_q, stop_q;
  logic load_p, tick_p, start_p, stop_p;

  logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
  logic       cur_zero, dec_zero, digit_ok;

  always_comb begin
    load_p  = load    & ~load_q;
    tick_p  = pgt_1hz & ~tick_q;
    start_p = start   & ~start_q;
    stop_p  = stop    & ~stop_q;
  end

  assign digit_ok = (digit <= DIGIT_MAX);
  assign cur_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                    (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

  // One-second BCD decrement with borrow rippling from seconds into minutes.
  always_comb begin
    dec_min_tens = min_tens_q;
    dec_min_ones = min_ones_q;
    dec_sec_tens = sec_tens_q;
    dec_sec_ones = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_sec_ones = sec_ones_q - 4'd1;
    end else begin
      dec_sec_ones = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_sec_tens = sec_tens_q - 4'd1;
      end else begin
        dec_sec_tens = SEC_TENS_MAX;
        if (min_ones_q != 4'd0) begin
          dec_min_ones = min_ones_q - 4'd1;
        end else begin
          dec_min_ones = 4'd9;
          dec_min_tens = min_tens_q - 4'd1;
        end
      end
    end
  end

  assign dec_zero = (dec_min_tens == 4'd0) && (dec_min_ones == 4'd0) &&
                    (dec_sec_tens == 4'd0) && (dec_sec_ones == 4'd0);

  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (stop_p) begin
          min_tens_d = '0;
          min_ones_d = '0;
          sec_tens_d = '0;
          sec_ones_d = '0;
          state_d    = S_IDLE;
        end else if (start_p) begin
          if (!cur_zero) state_d = S_RUN;
        end else if (load_p && digit_ok) begin
          min_tens_d = min_ones_q;
          min_ones_d = sec_tens_q;
          sec_tens_d = sec_ones_q;
          sec_ones_d = digit;
        end
      end
      S_RUN: begin
        if (stop_p) begin
          state_d = S_PAUSE;
        end else if (tick_p) begin
          min_tens_d = dec_min_tens;
          min_ones_d = dec_min_ones;
          sec_tens_d = dec_sec_tens;
          sec_ones_d = dec_sec_ones;
          if (dec_zero) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (stop_p || start_p) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q    <= S_IDLE;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      load_q     <= 1'b0;
      tick_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      load_q     <= load;
      tick_q     <= pgt_1hz;
      start_q    <= start;
      stop_q     <= stop;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign running  = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign zero     = cur_zero;

endmodule

// File: tb/tb_bcd_time_loader.sv
// Bench for bcd_time_loader: directed scenarios plus randomized traffic checked
// against a decimal-arithmetic reference model.
module tb_bcd_time_loader;
  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       load = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       pgt_1hz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, zero;
  logic [18:0] obs;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  int unsigned m_val;
  mstate_t     m_state;
  bit          m_load, m_tick, m_start, m_stop;

  bcd_time_loader #(.SEC_TENS_MAX(4'd5), .DIGIT_MAX(4'd9)) dut (
    .clk(clk), .clearn(clearn), .load(load), .digit(digit), .pgt_1hz(pgt_1hz),
    .start(start), .stop(stop), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running), .done(done),
    .zero(zero)
  );

  always #5 clk = ~clk;

  assign obs = {min_tens, min_ones, sec_tens, sec_ones, running, done, zero};

  // Time value kept as a decimal integer MMSS.
  function automatic logic [18:0] exp_of(int unsigned v, mstate_t s);
    logic [3:0] a, b, c, d;
    a = 4'(v / 1000);
    b = 4'((v / 100) % 10);
    c = 4'((v / 10) % 10);
    d = 4'(v % 10);
    return {a, b, c, d, s == M_RUN, s == M_DONE, v == 0};
  endfunction

  task automatic model_reset();
    m_val = 0; m_state = M_IDLE;
    m_load = 0; m_tick = 0; m_start = 0; m_stop = 0;
  endtask

  task automatic model_edge();
    bit lp, tp, sp, pp;
    int unsigned sec, mins;
    if (!clearn) begin
      model_reset();
      return;
    end
    lp = load && !m_load;
    tp = pgt_1hz && !m_tick;
    sp = start && !m_start;
    pp = stop && !m_stop;
    m_load = load; m_tick = pgt_1hz; m_start = start; m_stop = stop;
    case (m_state)
      M_IDLE, M_PAUSE: begin
        if (pp) begin
          m_val = 0; m_state = M_IDLE;
        end else if (sp) begin
          if (m_val != 0) m_state = M_RUN;
        end else if (lp && digit <= 9) begin
          m_val = (m_val % 1000) * 10 + digit;
        end
      end
      M_RUN: begin
        if (pp) m_state = M_PAUSE;
        else if (tp) begin
          sec = m_val % 100;
          mins = m_val / 100;
          if (sec > 0) sec = sec - 1;
          else begin sec = 59; mins = mins - 1; end
          m_val = mins * 100 + sec;
          if (m_val == 0) m_state = M_DONE;
        end
      end
      default: if (pp || sp) m_state = M_IDLE;
    endcase
  endtask

  task automatic clk1();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    load = 1'b1; digit = d;
    repeat (5) clk1();
    load = 1'b0;
    repeat (2) clk1();
  endtask

  task automatic do_start();
    start = 1'b1; clk1(); clk1(); start = 1'b0; clk1();
  endtask

  task automatic do_stop();
    stop = 1'b1; clk1(); clk1(); stop = 1'b0; clk1();
  endtask

  task automatic do_tick();
    pgt_1hz = 1'b1; clk1(); clk1(); pgt_1hz = 1'b0; clk1(); clk1();
  endtask

  task automatic test_reset();
    logic [18:0] e;
    clearn = 1'b0;
    repeat (2) clk1();
    clearn = 1'b1;
    clk1();
    e = exp_of(0, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL reset_state: got %h want %h", obs, e); end
  endtask

  task automatic test_entry();
    logic [18:0] e;
    key(4'd1);
    e = exp_of(1, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL entry_1: got %h want %h", obs, e); end
    key(4'd3);
    e = exp_of(13, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL entry_13: got %h want %h", obs, e); end
    key(4'd0);
    e = exp_of(130, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL entry_130: got %h want %h", obs, e); end
    key(4'd4); key(4'd5);
    e = exp_of(3045, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL entry_5th_digit: got %h want %h", obs, e); end
    do_stop();
    e = exp_of(0, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL idle_stop_clear: got %h want %h", obs, e); end
    key(4'd7); key(4'd5); do_start(); do_tick();
    e = exp_of(74, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL sec_75_dec: got %h want %h", obs, e); end
    do_stop(); do_stop();
  endtask

  task automatic test_async_reset();
    logic [18:0] e;
    key(4'd1); key(4'd3); key(4'd0); do_start();
    repeat (3) clk1();
    e = exp_of(130, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL run_0130: got %h want %h", obs, e); end
    #2;
    clearn = 1'b0;
    model_reset();
    #1;
    e = exp_of(0, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL async_reset: got %h want %h", obs, e); end
    load = 1'b1; digit = 4'd3;
    clk1(); clk1();
    clearn = 1'b1;
    clk1(); clk1();
    e = exp_of(3, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL load_high_at_release: got %h want %h", obs, e); end
    load = 1'b0; clk1(); clk1();
    do_stop();
  endtask

  task automatic test_countdown();
    logic [18:0] e;
    key(4'd1); key(4'd0); key(4'd0); do_start();
    e = exp_of(100, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL cd_start: got %h want %h", obs, e); end
    do_tick();
    e = exp_of(59, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL cd_borrow_min: got %h want %h", obs, e); end
    repeat (58) do_tick();
    e = exp_of(1, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL cd_0001: got %h want %h", obs, e); end
    do_tick();
    e = exp_of(0, M_DONE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL cd_done: got %h want %h", obs, e); end
    key(4'd6);
    e = exp_of(0, M_DONE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL done_load_ignored: got %h want %h", obs, e); end
    do_start();
    e = exp_of(0, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL done_to_idle: got %h want %h", obs, e); end
  endtask

  task automatic test_pause();
    logic [18:0] e;
    key(4'd5); do_start(); do_stop();
    e = exp_of(5, M_PAUSE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL pause_hold: got %h want %h", obs, e); end
    do_tick(); do_tick();
    e = exp_of(5, M_PAUSE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL pause_ticks: got %h want %h", obs, e); end
    do_start(); do_tick();
    e = exp_of(4, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL resume_tick: got %h want %h", obs, e); end
    do_stop(); do_stop();
    e = exp_of(0, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL double_stop: got %h want %h", obs, e); end
  endtask

  task automatic test_ignore();
    logic [18:0] e;
    do_start();
    e = exp_of(0, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL start_at_zero: got %h want %h", obs, e); end
    key(4'hC);
    e = exp_of(0, M_IDLE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL bad_digit: got %h want %h", obs, e); end
    key(4'd7); do_start(); key(4'd3);
    e = exp_of(7, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL load_in_run: got %h want %h", obs, e); end
    do_stop(); do_stop();
  endtask

  task automatic test_same_cycle();
    logic [18:0] e;
    key(4'd1); key(4'd0); do_start();
    pgt_1hz = 1'b1; stop = 1'b1;
    clk1();
    e = exp_of(10, M_PAUSE); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL tick_stop_same: got %h want %h", obs, e); end
    pgt_1hz = 1'b0; stop = 1'b0; clk1();
    do_stop();
    key(4'd2);
    start = 1'b1; load = 1'b1; digit = 4'd5;
    clk1();
    e = exp_of(2, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL start_load_same: got %h want %h", obs, e); end
    repeat (4) clk1();
    start = 1'b0; load = 1'b0; clk1();
    e = exp_of(2, M_RUN); n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL start_load_after: got %h want %h", obs, e); end
    do_stop(); do_stop();
  endtask

  task automatic test_random();
    logic [18:0] e;
    for (int i = 0; i < 4000; i++) begin
      load    = 1'($urandom_range(0, 1));
      digit   = 4'($urandom_range(0, 15));
      pgt_1hz = 1'($urandom_range(0, 1));
      start   = ($urandom % 8) == 0;
      stop    = ($urandom % 40) == 0;
      clk1();
      e = exp_of(m_val, m_state); n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL random_cycle_%0d: got %h want %h", i, obs, e);
      end
    end
    load = 1'b0; pgt_1hz = 1'b0; start = 1'b0; stop = 1'b0;
    clk1();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_entry();
    test_async_reset();
    test_countdown();
    test_pause();
    test_ignore();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
